// File: rtl/reset_sequencer.sv
// Board reset supervisor: debounced pushbutton, staggered system/CPU reset release.
// Optional watchdog enabled by defining RESET_SEQ_WDOG_EN.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned HOLD_CYCLES     = 1048576,
    parameter int unsigned STAGGER_CYCLES  = 256,
    parameter int unsigned WDOG_CYCLES     = 16777216
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_n,
    input  logic       btn_invert,
    input  logic       wdog_kick,
    output logic       sys_reset_n,
    output logic       cpu_reset_n,
    output logic       seq_busy,
    output logic [7:0] reset_count,
    output logic       wdog_fired
);

    localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned StagW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

    typedef enum logic [1:0] {S_HOLD, S_STAGGER, S_RUN} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_deb;
    logic [DebW-1:0]        r_deb_cnt;
    logic [DebW-1:0]        w_deb_cnt_d;
    logic                   w_deb_d;
    logic                   w_synced;

    state_t                 r_state;
    state_t                 w_state_d;
    logic [HoldW-1:0]       r_hold_cnt;
    logic [HoldW-1:0]       w_hold_d;
    logic [StagW-1:0]       r_stag_cnt;
    logic [StagW-1:0]       w_stag_d;
    logic                   w_trigger;

    logic                   r_sys;
    logic                   r_cpu;
    logic                   r_busy;
    logic [7:0]             r_count;

`ifdef RESET_SEQ_WDOG_EN
    localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [WdogW-1:0]       r_wdog_cnt;
    logic [WdogW-1:0]       w_wdog_d;
    logic                   w_wdog_trip;
    logic                   r_wdog_fired;
`else
    logic                   w_unused_kick;
    assign w_unused_kick = wdog_kick;
`endif

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
    always_comb begin
        w_deb_cnt_d = '0;
        w_deb_d     = r_deb;
        if (w_synced != r_deb) begin
            if (r_deb_cnt == DebW'(DEBOUNCE_CYCLES - 1)) begin
                w_deb_d = w_synced;
            end else begin
                w_deb_cnt_d = r_deb_cnt + DebW'(1);
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_hold_d  = '0;
        w_stag_d  = '0;
        w_trigger = 1'b0;
`ifdef RESET_SEQ_WDOG_EN
        w_wdog_d    = '0;
        w_wdog_trip = 1'b0;
`endif
        unique case (r_state)
            S_HOLD: begin
                if (!r_deb) begin
                    if (r_hold_cnt == HoldW'(HOLD_CYCLES - 1)) begin
                        w_state_d = S_STAGGER;
                    end else begin
                        w_hold_d = r_hold_cnt + HoldW'(1);
                    end
                end
            end
            S_STAGGER: begin
                if (r_deb) begin
                    w_state_d = S_HOLD;
                    w_trigger = 1'b1;
                end else if (r_stag_cnt == StagW'(STAGGER_CYCLES - 1)) begin
                    w_state_d = S_RUN;
                end else begin
                    w_stag_d = r_stag_cnt + StagW'(1);
                end
            end
            S_RUN: begin
                if (r_deb) begin
                    w_state_d = S_HOLD;
                    w_trigger = 1'b1;
                end
`ifdef RESET_SEQ_WDOG_EN
                // A kick on the terminal cycle takes priority over the timeout.
                else if (!wdog_kick) begin
                    if (r_wdog_cnt == WdogW'(WDOG_CYCLES - 1)) begin
                        w_state_d   = S_HOLD;
                        w_trigger   = 1'b1;
                        w_wdog_trip = 1'b1;
                    end else begin
                        w_wdog_d = r_wdog_cnt + WdogW'(1);
                    end
                end
`endif
            end
            default: w_state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= '0;
            r_deb      <= 1'b0;
            r_deb_cnt  <= '0;
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_stag_cnt <= '0;
            r_sys      <= 1'b0;
            r_cpu      <= 1'b0;
            r_busy     <= 1'b1;
            r_count    <= 8'd0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], ~button_n ^ btn_invert};
            r_deb      <= w_deb_d;
            r_deb_cnt  <= w_deb_cnt_d;
            r_state    <= w_state_d;
            r_hold_cnt <= w_hold_d;
            r_stag_cnt <= w_stag_d;
            // Outputs decoded from the next state so they change on the transition edge.
            r_sys      <= (w_state_d != S_HOLD);
            r_cpu      <= (w_state_d == S_RUN);
            r_busy     <= (w_state_d != S_RUN);
            if (w_trigger && (r_count != 8'hFF)) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

`ifdef RESET_SEQ_WDOG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog_cnt   <= '0;
            r_wdog_fired <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_d;
            if (w_wdog_trip) begin
                r_wdog_fired <= 1'b1;
            end
        end
    end
    assign wdog_fired = r_wdog_fired;
`else
    assign wdog_fired = 1'b0;
`endif

    assign sys_reset_n = r_sys;
    assign cpu_reset_n = r_cpu;
    assign seq_busy    = r_busy;
    assign reset_count = r_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small timing parameters.
// Watchdog scenarios run only when RESET_SEQ_WDOG_EN is defined.
module tb_reset_sequencer;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 4;
    localparam int unsigned HOLD  = 16;
    localparam int unsigned STAG  = 8;
    localparam int unsigned WDOG  = 32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       button_n;
    logic       btn_invert;
    logic       wdog_kick;
    logic       sys_reset_n;
    logic       cpu_reset_n;
    logic       seq_busy;
    logic [7:0] reset_count;
    logic       wdog_fired;

    int vectors = 0;
    int errors  = 0;
    int exp_count = 0;

    reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAG),
        .WDOG_CYCLES    (WDOG)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .button_n   (button_n),
        .btn_invert (btn_invert),
        .wdog_kick  (wdog_kick),
        .sys_reset_n(sys_reset_n),
        .cpu_reset_n(cpu_reset_n),
        .seq_busy   (seq_busy),
        .reset_count(reset_count),
        .wdog_fired (wdog_fired)
    );

    always #5 clk = ~clk;

    // CPU reset must never be released while system reset is asserted.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            vectors++;
            if (cpu_reset_n === 1'b1 && sys_reset_n !== 1'b1) begin
                errors++;
                $display("FAIL cpu_before_sys: cpu_reset_n=%b sys_reset_n=%b", cpu_reset_n,
                         sys_reset_n);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (cpu_reset_n === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        button_n   = 1'b1;
        btn_invert = 1'b0;
        wdog_kick  = 1'b0;
        repeat (3) step();
        vectors++;
        if ({sys_reset_n, cpu_reset_n, seq_busy, reset_count, wdog_fired} !== 12'b0_0_1_00000000_0)
        begin
            errors++;
            $display("FAIL reset_state: got %b expected 001000000000",
                     {sys_reset_n, cpu_reset_n, seq_busy, reset_count, wdog_fired});
        end
        reset_n   = 1'b1;
        exp_count = 0;
        repeat (15) step();
        vectors++;
        if (sys_reset_n !== 1'b0 || seq_busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_edge15: sys=%b busy=%b expected sys=0 busy=1", sys_reset_n,
                     seq_busy);
        end
        step();
        vectors++;
        if (sys_reset_n !== 1'b1 || cpu_reset_n !== 1'b0) begin
            errors++;
            $display("FAIL sys_rise_edge16: sys=%b cpu=%b expected sys=1 cpu=0", sys_reset_n,
                     cpu_reset_n);
        end
        repeat (7) step();
        vectors++;
        if (cpu_reset_n !== 1'b0 || seq_busy !== 1'b1) begin
            errors++;
            $display("FAIL stagger_edge23: cpu=%b busy=%b expected cpu=0 busy=1", cpu_reset_n,
                     seq_busy);
        end
        step();
        vectors++;
        if (cpu_reset_n !== 1'b1 || seq_busy !== 1'b0 || reset_count !== 8'd0) begin
            errors++;
            $display("FAIL cpu_rise_edge24: cpu=%b busy=%b count=%0d expected cpu=1 busy=0 count=0",
                     cpu_reset_n, seq_busy, reset_count);
        end
    endtask

    task automatic test_press();
        button_n = 1'b0;
        repeat (6) step();
        vectors++;
        if (sys_reset_n !== 1'b1) begin
            errors++;
            $display("FAIL press_early: sys=%b expected 1 six edges after press", sys_reset_n);
        end
        step();
        exp_count++;
        vectors++;
        if (sys_reset_n !== 1'b0 || cpu_reset_n !== 1'b0 || seq_busy !== 1'b1 ||
            reset_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL press_fall: sys=%b cpu=%b busy=%b count=%0d expected 0 0 1 %0d",
                     sys_reset_n, cpu_reset_n, seq_busy, reset_count, exp_count);
        end
        repeat (3) step();
        button_n = 1'b1;
        repeat (21) step();
        vectors++;
        if (sys_reset_n !== 1'b0) begin
            errors++;
            $display("FAIL release_early: sys=%b expected 0", sys_reset_n);
        end
        step();
        vectors++;
        if (sys_reset_n !== 1'b1 || cpu_reset_n !== 1'b0) begin
            errors++;
            $display("FAIL release_sys_rise: sys=%b cpu=%b expected 1 0", sys_reset_n,
                     cpu_reset_n);
        end
        repeat (8) step();
        vectors++;
        if (cpu_reset_n !== 1'b1) begin
            errors++;
            $display("FAIL release_cpu_rise: cpu=%b expected 1", cpu_reset_n);
        end
    endtask

    task automatic test_bounce();
        int drops = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) button_n = ~button_n;
`ifdef RESET_SEQ_WDOG_EN
            wdog_kick = (i % 16 == 0);
`endif
            step();
            if (sys_reset_n !== 1'b1 || cpu_reset_n !== 1'b1) drops++;
        end
        wdog_kick = 1'b0;
        button_n  = 1'b1;
        repeat (8) step();
        vectors++;
        if (drops != 0 || sys_reset_n !== 1'b1 || reset_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL bounce: drops=%0d sys=%b count=%0d expected drops=0 sys=1 count=%0d",
                     drops, sys_reset_n, reset_count, exp_count);
        end
    endtask

    task automatic test_invert();
        bit ok;
        btn_invert = 1'b1;
        button_n   = 1'b0;
        repeat (10) step();
        vectors++;
        if (sys_reset_n !== 1'b1 || cpu_reset_n !== 1'b1) begin
            errors++;
            $display("FAIL invert_idle: sys=%b cpu=%b expected 1 1", sys_reset_n, cpu_reset_n);
        end
        button_n = 1'b1;
        repeat (6) step();
        vectors++;
        if (sys_reset_n !== 1'b1) begin
            errors++;
            $display("FAIL invert_early: sys=%b expected 1", sys_reset_n);
        end
        step();
        exp_count++;
        vectors++;
        if (sys_reset_n !== 1'b0 || reset_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL invert_press: sys=%b count=%0d expected 0 %0d", sys_reset_n,
                     reset_count, exp_count);
        end
        button_n = 1'b0;
        wait_run(60, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL invert_recover: cpu=%b expected 1 within 60 cycles", cpu_reset_n);
        end
        btn_invert = 1'b0;
        button_n   = 1'b1;
    endtask

    task automatic test_stagger_press();
        bit ok;
        bit cpu_rose = 1'b0;
        reset_n = 1'b0;
        repeat (2) step();
        reset_n   = 1'b1;
        exp_count = 0;
        repeat (16) step();
        vectors++;
        if (sys_reset_n !== 1'b1 || cpu_reset_n !== 1'b0) begin
            errors++;
            $display("FAIL stg_entry: sys=%b cpu=%b expected 1 0", sys_reset_n, cpu_reset_n);
        end
        button_n = 1'b0;
        repeat (6) begin
            step();
            if (cpu_reset_n !== 1'b0) cpu_rose = 1'b1;
        end
        step();
        if (cpu_reset_n !== 1'b0) cpu_rose = 1'b1;
        exp_count++;
        vectors++;
        if (sys_reset_n !== 1'b0 || cpu_rose || reset_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL stg_press: sys=%b cpu_rose=%b count=%0d expected 0 0 %0d",
                     sys_reset_n, cpu_rose, reset_count, exp_count);
        end
        repeat (3) step();
        button_n = 1'b1;
        wait_run(80, ok);
        vectors++;
        if (!ok || reset_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL stg_recover: ok=%b count=%0d expected 1 %0d", ok, reset_count,
                     exp_count);
        end
    endtask

    task automatic test_async_mid_stagger();
        bit ok;
        while (exp_count < 3) begin
            button_n = 1'b0;
            repeat (10) step();
            button_n = 1'b1;
            exp_count++;
            ok = 1'b0;
            for (int i = 0; i < 60 && !ok; i++) begin
                step();
                if (sys_reset_n === 1'b1) ok = 1'b1;
            end
            if (exp_count < 3) wait_run(20, ok);
        end
        repeat (3) step();
        vectors++;
        if (sys_reset_n !== 1'b1 || cpu_reset_n !== 1'b0 || reset_count !== 8'd3) begin
            errors++;
            $display("FAIL async_pre: sys=%b cpu=%b count=%0d expected 1 0 3", sys_reset_n,
                     cpu_reset_n, reset_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({sys_reset_n, cpu_reset_n, seq_busy, reset_count} !== 11'b0_0_1_00000000) begin
            errors++;
            $display("FAIL async_clear: got %b expected 00100000000",
                     {sys_reset_n, cpu_reset_n, seq_busy, reset_count});
        end
        test_reset();
    endtask

`ifdef RESET_SEQ_WDOG_EN
    task automatic test_wdog();
        bit ok;
        int drops = 0;
        repeat (31) step();
        vectors++;
        if (sys_reset_n !== 1'b1 || wdog_fired !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early: sys=%b fired=%b expected 1 0", sys_reset_n, wdog_fired);
        end
        step();
        exp_count++;
        vectors++;
        if (sys_reset_n !== 1'b0 || wdog_fired !== 1'b1 || reset_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL wdog_trip: sys=%b fired=%b count=%0d expected 0 1 %0d", sys_reset_n,
                     wdog_fired, reset_count, exp_count);
        end
        wait_run(60, ok);
        repeat (31) step();
        wdog_kick = 1'b1;
        step();
        wdog_kick = 1'b0;
        vectors++;
        if (!ok || sys_reset_n !== 1'b1 || wdog_fired !== 1'b1) begin
            errors++;
            $display("FAIL wdog_terminal_kick: ok=%b sys=%b fired=%b expected 1 1 1", ok,
                     sys_reset_n, wdog_fired);
        end
        for (int i = 0; i < 1000; i++) begin
            wdog_kick = (i % 20 == 0);
            step();
            if (sys_reset_n !== 1'b1) drops++;
        end
        wdog_kick = 1'b0;
        vectors++;
        if (drops != 0 || reset_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL wdog_kicked: drops=%0d count=%0d expected 0 %0d", drops,
                     reset_count, exp_count);
        end
    endtask
`else
    task automatic test_no_wdog();
        int drops = 0;
        for (int i = 0; i < 100; i++) begin
            wdog_kick = (i % 37 == 5);
            step();
            if (sys_reset_n !== 1'b1 || cpu_reset_n !== 1'b1) drops++;
        end
        wdog_kick = 1'b0;
        vectors++;
        if (drops != 0 || wdog_fired !== 1'b0 || reset_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL no_wdog: drops=%0d fired=%b count=%0d expected 0 0 %0d", drops,
                     wdog_fired, reset_count, exp_count);
        end
    endtask
`endif

    initial begin
        reset_n    = 1'b0;
        button_n   = 1'b1;
        btn_invert = 1'b0;
        wdog_kick  = 1'b0;
        test_reset();
        test_press();
        test_bounce();
        test_invert();
        test_stagger_press();
        test_async_mid_stagger();
`ifdef RESET_SEQ_WDOG_EN
        test_wdog();
`else
        test_no_wdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
